// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if: instruction-in / immediate-out handshake bundle for imm_gen_stage.
interface imm_gen_stage_if #(parameter int XLEN = 32);
    logic            valid_i;
    logic            ready_o;
    logic [31:0]     instruction_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] immediate_o;
    logic [2:0]      fmt_o;
    logic [31:0]     instruction_o;
    modport slave (
        input  valid_i, instruction_i, ready_i,
        output ready_o, valid_o, immediate_o, fmt_o, instruction_o
    );
    modport master (
        output valid_i, instruction_i, ready_i,
        input  ready_o, valid_o, immediate_o, fmt_o, instruction_o
    );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate decoder feeding a 2-entry elastic buffer, with a saturating illegal-opcode counter.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    imm_gen_stage_if.slave   bus,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] illegal_cnt_o
);
    typedef enum logic [2:0] {F_NONE, F_I, F_S, F_B, F_U, F_J, F_SHAMT, F_ILL} fmt_t;
    localparam bit W64 = XLEN == 64;
    logic [31:0]     ins;
    logic [6:0]      op;
    logic            shift;
    fmt_t            fmt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] mem_imm [2];
    logic [2:0]      mem_fmt [2];
    logic [31:0]     mem_ins [2];
    logic            wp, rp;
    logic [1:0]      cnt;
    logic            push, pop;
    assign ins   = bus.instruction_i;
    assign op    = ins[6:0];
    assign shift = ins[13:12] == 2'b01;
    // Every legal opcode ends in 2'b11, so the default arm also covers the legality check.
    always_comb begin
        case (op)
            7'h33:                      fmt = F_NONE;
            7'h13:                      fmt = shift ? F_SHAMT : F_I;
            7'h1B:                      fmt = !W64 ? F_ILL : shift ? F_SHAMT : F_I;
            7'h3B:                      fmt = W64 ? F_NONE : F_ILL;
            7'h03, 7'h67, 7'h73, 7'h0F: fmt = F_I;
            7'h23:                      fmt = F_S;
            7'h63:                      fmt = F_B;
            7'h37, 7'h17:               fmt = F_U;
            7'h6F:                      fmt = F_J;
            default:                    fmt = F_ILL;
        endcase
    end
    always_comb begin
        imm = fmt == F_I     ? XLEN'($signed(ins[31:20])) :
              fmt == F_S     ? XLEN'($signed({ins[31:25], ins[11:7]})) :
              fmt == F_B     ? XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) :
              fmt == F_U     ? XLEN'($signed({ins[31:12], 12'b0})) :
              fmt == F_J     ? XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})) :
              fmt == F_SHAMT ? ((W64 && op == 7'h13) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20])) :
                               '0;
    end
    assign bus.ready_o       = !reset && cnt != 2'd2;
    assign bus.valid_o       = cnt != 2'd0;
    assign bus.immediate_o   = mem_imm[rp];
    assign bus.fmt_o         = mem_fmt[rp];
    assign bus.instruction_o = mem_ins[rp];
    assign push = bus.valid_i && bus.ready_o;
    assign pop  = bus.valid_o && bus.ready_i;
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_imm <= '{default: '0};
            mem_fmt <= '{default: '0};
            mem_ins <= '{default: '0};
            wp      <= 1'b0;
            rp      <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (push) begin
                mem_imm[wp] <= imm;
                mem_fmt[wp] <= fmt;
                mem_ins[wp] <= ins;
            end
            wp  <= wp ^ push;
            rp  <= rp ^ pop;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (reset || clr_cnt_i)
            illegal_cnt_o <= '0;
        else if (push && fmt == F_ILL && illegal_cnt_o != '1)
            illegal_cnt_o <= illegal_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: 32-bit and 64-bit instances driven in lockstep against a queue-based reference model.
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ins = '0;
    logic [15:0] cnt32;
    logic [1:0]  cnt64;
    logic [31:0] q[$];
    int          c32, c64;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32)) b32 ();
    imm_gen_stage_if #(.XLEN(64)) b64 ();
    assign b32.valid_i = valid;
    assign b32.instruction_i = ins;
    assign b32.ready_i = ready;
    assign b64.valid_i = valid;
    assign b64.instruction_i = ins;
    assign b64.ready_i = ready;

    imm_gen_stage #(.XLEN(32), .CNT_W(16)) u32 (
        .clk(clk), .reset(reset), .bus(b32.slave), .clr_cnt_i(clr), .illegal_cnt_o(cnt32)
    );
    imm_gen_stage #(.XLEN(64), .CNT_W(2)) u64 (
        .clk(clk), .reset(reset), .bus(b64.slave), .clr_cnt_i(clr), .illegal_cnt_o(cnt64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the format rules, widened to 64 bits then cut to the datapath width.
    function automatic void ref_dec(input logic [31:0] i, input bit w64,
                                    output logic [2:0] f, output logic [63:0] m);
        logic [6:0]        o = i[6:0];
        bit                sh = (i[14:12] == 3'd1) || (i[14:12] == 3'd5);
        logic signed [63:0] v = '0;
        f = 3'd7;
        if (o == 7'h33 || (w64 && o == 7'h3B)) f = 3'd0;
        else if ((o == 7'h13 || (w64 && o == 7'h1B)) && sh) begin
            f = 3'd6;
            v = (w64 && o == 7'h13) ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
        end else if (o inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F} || (w64 && o == 7'h1B)) begin
            f = 3'd1;
            v = $signed(i[31:20]);
        end else if (o == 7'h23) begin
            f = 3'd2;
            v = $signed({i[31:25], i[11:7]});
        end else if (o == 7'h63) begin
            f = 3'd3;
            v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
        end else if (o == 7'h37 || o == 7'h17) begin
            f = 3'd4;
            v = $signed({i[31:12], 12'b0});
        end else if (o == 7'h6F) begin
            f = 3'd5;
            v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
        end
        m = w64 ? v : {32'b0, v[31:0]};
    endfunction

    task automatic check_all();
        logic [2:0]  f;
        logic [63:0] m;
        chk("valid32", b32.valid_o, q.size() != 0);
        chk("valid64", b64.valid_o, q.size() != 0);
        chk("ready32", b32.ready_o, q.size() < 2);
        chk("ready64", b64.ready_o, q.size() < 2);
        if (q.size() != 0) begin
            ref_dec(q[0], 1'b0, f, m);
            chk("fmt32", b32.fmt_o, f);
            chk("imm32", b32.immediate_o, m);
            chk("ins32", b32.instruction_o, q[0]);
            ref_dec(q[0], 1'b1, f, m);
            chk("fmt64", b64.fmt_o, f);
            chk("imm64", b64.immediate_o, m);
            chk("ins64", b64.instruction_o, q[0]);
        end
        chk("cnt32", cnt32, c32);
        chk("cnt64", cnt64, c64);
    endtask

    task automatic cycle(input logic v, input logic [31:0] i, input logic r, input logic c);
        logic [2:0]  f;
        logic [63:0] m;
        bit          push, pop;
        valid = v;
        ins = i;
        ready = r;
        clr = c;
        push = v && q.size() < 2;
        pop = q.size() != 0 && r;
        @(posedge clk);
        if (c) begin
            c32 = 0;
            c64 = 0;
        end else if (push) begin
            ref_dec(i, 1'b0, f, m);
            if (f == 3'd7 && c32 < 65535) c32++;
            ref_dec(i, 1'b1, f, m);
            if (f == 3'd7 && c64 < 3) c64++;
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(i);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b1;
        ins = 32'h0;
        clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid32", b32.valid_o, 0);
        chk("rst_valid64", b64.valid_o, 0);
        chk("rst_ready32", b32.ready_o, 0);
        chk("rst_ready64", b64.ready_o, 0);
        chk("rst_imm32", b32.immediate_o, 0);
        chk("rst_imm64", b64.immediate_o, 0);
        chk("rst_fmt", b32.fmt_o, 0);
        chk("rst_ins", b64.instruction_o, 0);
        chk("rst_cnt32", cnt32, 0);
        chk("rst_cnt64", cnt64, 0);
        q.delete();
        c32 = 0;
        c64 = 0;
        reset = 1'b0;
        valid = 1'b0;
    endtask

    logic [31:0] d_ins [11] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF,
                               32'h800002B7, 32'h01F09093, 32'h4030D093, 32'h02009093, 32'hFFF0809B,
                               32'h00B50533};
    logic [63:0] d_e32 [11] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'h12345000, 64'h800,
                               64'h80000000, 64'h1F, 64'h3, 64'h0, 64'h0, 64'h0};
    logic [63:0] d_e64 [11] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                               64'h12345000, 64'h800, 64'hFFFFFFFF80000000, 64'h1F, 64'h3, 64'h20,
                               64'hFFFFFFFFFFFFFFFF, 64'h0};
    logic [2:0]  d_f32 [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd6, 3'd6, 3'd6, 3'd7, 3'd0};
    logic [2:0]  d_f64 [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd6, 3'd6, 3'd6, 3'd1, 3'd0};
    logic [6:0]  ops [13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h1B, 7'h3B};

    initial begin
        logic [31:0] r, r2;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            cycle(1'b1, d_ins[k], 1'b1, 1'b0);
            chk("dir_imm32", b32.immediate_o, d_e32[k]);
            chk("dir_imm64", b64.immediate_o, d_e64[k]);
            chk("dir_fmt32", b32.fmt_o, d_f32[k]);
            chk("dir_fmt64", b64.fmt_o, d_f64[k]);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        // Backpressure: A and B fill the buffer, C waits until a slot frees.
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 1'b0, 1'b0);
        chk("bp_full_ready", b32.ready_o, 0);
        cycle(1'b1, 32'h00300093, 1'b0, 1'b0);
        chk("bp_head_a", b32.instruction_o, 32'h00100093);
        cycle(1'b1, 32'h00300093, 1'b1, 1'b0);
        chk("bp_head_b", b32.instruction_o, 32'h00200093);
        cycle(1'b1, 32'h00300093, 1'b1, 1'b0);
        chk("bp_head_c", b64.instruction_o, 32'h00300093);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_drained", b32.valid_o, 0);
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_rst_ready", b32.ready_o, 1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'h0, 1'b1, 1'b0);
            chk("sat_cnt64", cnt64, (k < 3) ? k + 1 : 3);
            chk("sat_fmt", b64.fmt_o, 3'd7);
        end
        cycle(1'b1, 32'h0, 1'b1, 1'b1);
        chk("clr_cnt32", cnt32, 0);
        chk("clr_cnt64", cnt64, 0);
        for (int k = 0; k < 400; k++) begin
            r = $urandom();
            r2 = $urandom();
            cycle(r2[0] | r2[1], {r[31:7], (r2[7:4] < 4'd13) ? ops[r2[7:4]] : r[6:0]},
                  r2[2] | r2[3], r2[15:10] == 6'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
